fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller for the dual-clock FIFO test path, running in the write clock domain. It waits for the FIFO to drain empty, then writes a wrapping incrementing data pattern until the FIFO reports almost_full. It pairs with the read-side controller, which drains on full and stops on almost_empty. It also counts completed bursts and flags any write attempted into a full FIFO.

Parameters:
DATA_W, 8, width of fifo_wr_data and of the pattern counter
DATA_INIT, 0, first pattern value after reset
DELAY_CYC, 10, settle cycles between detecting empty and starting a burst (range 1..255)
CNT_W, 16, width of burst_cnt

Ports:
wr_clk  in  1  write-domain clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_rst_busy  in  1  FIFO write-side reset in progress; no writes allowed while high
empty  in  1  FIFO empty flag, read-clock domain, asynchronous to wr_clk
almost_full  in  1  FIFO almost-full flag, wr_clk domain; high means at most one free slot
full  in  1  FIFO full flag, wr_clk domain
fifo_wr_en  out  1  registered FIFO write enable
fifo_wr_data  out  DATA_W  registered write data, valid when fifo_wr_en=1
burst_cnt  out  CNT_W  number of completed bursts, wraps modulo 2^CNT_W
busy  out  1  high in DELAY and WRITE states
ovf_err  out  1  sticky: a write was issued while full=1

Behaviour:
- Reset values (rst=1 at an edge): state IDLE; fifo_wr_en=0; fifo_wr_data=DATA_INIT; burst_cnt=0; busy=0; ovf_err=0; both sync flops=0; delay counter=0.
- Empty synchroniser: two flops, empty_d0 <= empty, empty_d1 <= empty_d0. Only empty_d1 is used. Detection latency is 2-3 wr_clk cycles.
- State IDLE: go to WAIT_EMPTY when wr_rst_busy=0.
- State WAIT_EMPTY: on empty_d1=1, clear the delay counter and go to DELAY.
- State DELAY: increment the delay counter each cycle. When it equals DELAY_CYC-1, go to WRITE and set fifo_wr_en=1 at the same edge. The first write beat therefore appears exactly DELAY_CYC cycles after the edge that sampled empty_d1=1.
- State WRITE: fifo_wr_en stays 1.
  - At any edge where almost_full=1 and fifo_wr_en=1: fifo_wr_en <= 0, burst_cnt <= burst_cnt+1, next state WAIT_EMPTY.
  - The beat in flight at that edge is the final write and fills the last slot.
- Data: at every edge where fifo_wr_en=1 and full=0, fifo_wr_data <= fifo_wr_data+1, modulo 2^DATA_W (e.g. 0xFF wraps to 0x00). The value is held otherwise. The pattern is continuous across bursts and is not reset by wr_rst_busy.
- Overflow: at any edge with fifo_wr_en=1 and full=1, ovf_err <= 1. It clears only on rst. Data does not advance on that beat.
- wr_rst_busy=1 at any edge, in any state: fifo_wr_en <= 0, next state IDLE, delay counter cleared, burst_cnt unchanged. A burst aborted this way is not counted. Priority: wr_rst_busy over the almost_full exit.
- Simultaneous almost_full=1 and empty_d1=1 in WAIT_EMPTY: the empty transition wins. The stale empty flag is a known artefact; DELAY_CYC absorbs it.
- busy = (state==DELAY) or (state==WRITE), registered with the state.
- rst=1 mid-burst: all outputs return to their reset values at that edge. No partial-cycle behaviour.

Decomposition:
- Shared package fifo_test_pkg holds:
  - the state enum (IDLE, WAIT_EMPTY, DELAY, WRITE; 2-bit encoding 0..3)
  - default widths DATA_W=8 and CNT_W=16
  - DELAY_CYC default, shared with the read-side controller
- One natural sub-module: sync_2ff, a single-bit two-flop synchroniser with synchronous active-high reset to 0. It is reusable for the read side's full synchronisation.

Test Plan:
- Reset then wr_rst_busy=0, empty=1, FIFO depth 16 (almost_full at 15 entries), DATA_INIT=0, DELAY_CYC=10 -> required response:
  - first fifo_wr_en=1 exactly 12-13 cycles after empty rises
  - 16 beats carrying data 0x00..0x0F
  - fifo_wr_en=0 one cycle after almost_full rises
  - burst_cnt=1, ovf_err=0
- Reader drains to empty, second burst -> data continues 0x10..0x1F, burst_cnt=2; run to wrap (DATA_W=8) -> data after 0xFF is 0x00.
- wr_rst_busy pulsed high for 5 cycles mid-WRITE -> fifo_wr_en=0 at the next edge; state IDLE; burst_cnt unchanged; data resumes from the held value after re-trigger.
- Force full=1 while fifo_wr_en=1 (almost_full stuck 0) -> ovf_err=1 next edge; data not incremented on that beat; ovf_err stays 1 until rst.
- empty toggling 1-0 within one cycle (glitch shorter than the wr_clk period) -> no entry to DELAY unless it is captured by empty_d0; no X on outputs.
- rst asserted during DELAY and during WRITE -> all outputs equal their reset values the next cycle; fifo_wr_data=DATA_INIT.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// Shared types and defaults for the dual-clock FIFO test-path controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: controller state enum, default data/count widths, and the settle
// delay default used by both the write-side and read-side controllers.
package fifo_test_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_DELAY_CYC = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EMPTY = 2'd1,
    DELAY      = 2'd2,
    WRITE      = 2'd3
  } fifo_ctrl_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser into the clk domain.
// Latency: 2 clk edges from din to dout (2-3 cycles from an async change).
// Backpressure: none.
//
// Ports: clk (destination clock), rst (sync active-high, clears both flops),
//        din (asynchronous input), dout (synchronised output).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic stage0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage0 <= 1'b0;
      dout   <= 1'b0;
    end else begin
      stage0 <= din;
      dout   <= stage0;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO test controller: waits for empty, settles, then writes a
// wrapping incrementing pattern until almost_full. Latency: first beat
// DELAY_CYC edges after empty is seen synchronised. Backpressure: almost_full
// ends the burst (one final beat fills the last slot); full only flags ovf_err.
//
// Ports: wr_clk, rst (sync active-high), wr_rst_busy (abort/hold in IDLE),
//        empty (async, synchronised here), almost_full, full,
//        fifo_wr_en/fifo_wr_data (registered write port), burst_cnt,
//        busy (DELAY or WRITE), ovf_err (sticky write-into-full).
module fifo_wr_ctrl
  import fifo_test_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] DATA_INIT = '0,
  parameter int                DELAY_CYC = DEF_DELAY_CYC,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              wr_rst_busy,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              busy,
  output logic              ovf_err
);

  localparam logic [7:0] DELAY_LAST = 8'(DELAY_CYC - 1);

  fifo_ctrl_state_t  state, state_nxt;
  logic [7:0]        dly_cnt, dly_cnt_nxt;
  logic              wr_en_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [CNT_W-1:0]  burst_nxt;
  logic              busy_nxt;
  logic              ovf_nxt;
  logic              empty_sync;

  sync_2ff u_empty_sync (
    .clk  (wr_clk),
    .rst  (rst),
    .din  (empty),
    .dout (empty_sync)
  );

  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    burst_nxt   = burst_cnt;

    case (state)
      IDLE: state_nxt = WAIT_EMPTY;
      WAIT_EMPTY: begin
        // almost_full is deliberately ignored here: a stale empty wins and
        // the settle delay absorbs it.
        if (empty_sync) begin
          dly_cnt_nxt = '0;
          state_nxt   = DELAY;
        end
      end
      DELAY: begin
        if (dly_cnt == DELAY_LAST) begin
          state_nxt = WRITE;
        end else begin
          dly_cnt_nxt = dly_cnt + 8'd1;
        end
      end
      WRITE: begin
        // The beat already on the bus at this edge takes the last free slot.
        if (almost_full && fifo_wr_en) begin
          state_nxt = WAIT_EMPTY;
          burst_nxt = burst_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // FIFO reset in progress overrides everything; an aborted burst is not counted.
    if (wr_rst_busy) begin
      state_nxt   = IDLE;
      dly_cnt_nxt = '0;
      burst_nxt   = burst_cnt;
    end

    wr_en_nxt = (state_nxt == WRITE);
    busy_nxt  = (state_nxt == DELAY) || (state_nxt == WRITE);

    // Pattern advances only on beats the FIFO actually accepts.
    data_nxt = (fifo_wr_en && !full) ? fifo_wr_data + 1'b1 : fifo_wr_data;
    ovf_nxt  = ovf_err | (fifo_wr_en & full);
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state        <= IDLE;
      dly_cnt      <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= DATA_INIT;
      burst_cnt    <= '0;
      busy         <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      dly_cnt      <= dly_cnt_nxt;
      fifo_wr_en   <= wr_en_nxt;
      fifo_wr_data <= data_nxt;
      burst_cnt    <= burst_nxt;
      busy         <= busy_nxt;
      ovf_err      <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: startup vector table, a depth-16 FIFO
// model with a random-rate reader and random FIFO-reset pulses, and directed
// overflow, reset and empty-glitch sequences.
module tb_fifo_wr_ctrl;

  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int DC    = 10;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_rst_busy, empty, almost_full, full;
  logic          fifo_wr_en, busy, ovf_err;
  logic [DW-1:0] fifo_wr_data;
  logic [CW-1:0] burst_cnt;

  fifo_wr_ctrl #(
    .DATA_W    (DW),
    .DATA_INIT (INIT),
    .DELAY_CYC (DC),
    .CNT_W     (CW)
  ) dut (
    .wr_clk       (clk),
    .rst          (rst),
    .wr_rst_busy  (wr_rst_busy),
    .empty        (empty),
    .almost_full  (almost_full),
    .full         (full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .burst_cnt    (burst_cnt),
    .busy         (busy),
    .ovf_err      (ovf_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: FIFO occupancy, expected pattern, completed bursts.
  bit            model_on   = 0;
  bit            drain      = 0;
  bit            force_full = 0;
  bit            af_stuck0  = 0;
  int            q_cnt      = 0;
  logic [DW-1:0] exp_data   = INIT;
  int            exp_burst  = 0;
  int            beats      = 0;
  bit            prev_ff    = 0;
  bit            saw_wrap   = 0;

  typedef struct {
    logic          rst, wrb, emp, af, full;
    logic          wr_en, busy;
    logic [DW-1:0] data;
    logic [CW-1:0] burst;
    logic          ovf;
  } vec_t;

  vec_t vt[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, let the edge happen, update the model at +1.
  task automatic cycle();
    logic          we;
    logic [DW-1:0] wd;
    bit            acc, pop, bev, wev;
    @(negedge clk);
    we  = fifo_wr_en;
    wd  = fifo_wr_data;
    acc = model_on && (we === 1'b1) && !full;
    pop = model_on && drain && (q_cnt > 0) && ($urandom_range(0, 3) != 0);
    bev = model_on && !rst && !wr_rst_busy && (we === 1'b1) && almost_full;
    wev = model_on && !rst && wr_rst_busy;
    @(posedge clk);
    #1;
    if (acc) begin
      check("wr_data", 32'(wd), 32'(exp_data));
      if (prev_ff && wd == 8'h00) saw_wrap = 1;
      prev_ff  = (wd == 8'hFF);
      exp_data = exp_data + 1'b1;
      q_cnt++;
      beats++;
    end
    if (pop) q_cnt--;
    if (bev) begin
      exp_burst++;
      check("burst_end_cnt", 32'(burst_cnt), 32'(exp_burst));
      check("burst_end_wr_en", 32'(fifo_wr_en), 0);
      if (exp_burst <= 2) check("burst_beats", 32'(beats), 16);
      beats = 0;
    end
    if (wev) begin
      check("wrb_wr_en", 32'(fifo_wr_en), 0);
      check("wrb_busy", 32'(busy), 0);
      check("wrb_burst", 32'(burst_cnt), 32'(exp_burst));
      beats = 0;
    end
    if (model_on) begin
      if (q_cnt >= DEPTH) drain = 1;
      if (q_cnt == 0) drain = 0;
      empty       = (q_cnt == 0);
      almost_full = af_stuck0 ? 1'b0 : (q_cnt >= DEPTH - 1);
      full        = force_full || (q_cnt >= DEPTH);
    end
  endtask

  task automatic do_reset(input string name);
    rst         = 1'b1;
    wr_rst_busy = 1'b0;
    cycle();
    check({name, "_wr_en"}, 32'(fifo_wr_en), 0);
    check({name, "_data"},  32'(fifo_wr_data), 32'(INIT));
    check({name, "_burst"}, 32'(burst_cnt), 0);
    check({name, "_busy"},  32'(busy), 0);
    check({name, "_ovf"},   32'(ovf_err), 0);
    rst       = 1'b0;
    q_cnt     = 0;
    drain     = 0;
    exp_data  = INIT;
    exp_burst = 0;
    beats     = 0;
    prev_ff   = 0;
    if (model_on) begin
      empty       = 1'b1;
      almost_full = 1'b0;
      full        = 1'b0;
    end
  endtask

  task automatic wait_write(input string name);
    for (int i = 0; i < 200 && fifo_wr_en !== 1'b1; i++) cycle();
    check(name, 32'(fifo_wr_en), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            wrb_left;
    bit            did_wrb;
    logic [DW-1:0] held;
    int            busy_seen, x_seen;

    rst = 1'b1; wr_rst_busy = 1'b1; empty = 1'b0; almost_full = 1'b0; full = 1'b0;

    // Startup table: empty rises before edge 5, seen by the FSM at edge 7,
    // first beat at edge 17, almost_full at edge 20 ends the burst.
    for (int i = 0; i < 22; i++) begin
      vt[i] = '{rst: 1'b0, wrb: 1'b0, emp: 1'b0, af: 1'b0, full: 1'b0,
                wr_en: 1'b0, busy: 1'b0, data: INIT, burst: '0, ovf: 1'b0};
      if (i < 2)              begin vt[i].rst = 1'b1; vt[i].wrb = 1'b1; end
      if (i == 2)             vt[i].wrb = 1'b1;
      if (i >= 5 && i <= 16)  vt[i].emp = 1'b1;
      if (i >= 7 && i <= 19)  vt[i].busy = 1'b1;
      if (i >= 17 && i <= 20) begin
        vt[i].wr_en = (i != 20);
        vt[i].data  = 8'(i - 17);
      end
      if (i == 20)            vt[i].af = 1'b1;
      if (i >= 20)            vt[i].burst = 16'd1;
      if (i == 21)            vt[i].data = 8'h03;
    end
    for (int i = 0; i < 22; i++) begin
      rst = vt[i].rst; wr_rst_busy = vt[i].wrb; empty = vt[i].emp;
      almost_full = vt[i].af; full = vt[i].full;
      cycle();
      check($sformatf("vec%0d", i),
            32'({fifo_wr_en, busy, fifo_wr_data, burst_cnt, ovf_err}),
            32'({vt[i].wr_en, vt[i].busy, vt[i].data, vt[i].burst, vt[i].ovf}));
    end

    // Modelled FIFO with random reader and FIFO-reset pulses.
    model_on = 1;
    do_reset("rst_model");
    wrb_left = 0;
    did_wrb  = 0;
    for (int c = 0; c < 6000 && exp_burst < 24; c++) begin
      if (wrb_left > 0) begin
        wr_rst_busy = 1'b1;
        wrb_left--;
      end else begin
        wr_rst_busy = 1'b0;
        if (!did_wrb && exp_burst == 3 && beats == 5 && fifo_wr_en === 1'b1) begin
          did_wrb = 1; wrb_left = 4; wr_rst_busy = 1'b1; drain = 1;
        end else if (exp_burst >= 4 && $urandom_range(0, 119) == 0) begin
          wrb_left = $urandom_range(0, 4); wr_rst_busy = 1'b1; drain = 1;
        end
      end
      cycle();
    end
    wr_rst_busy = 1'b0;
    check("bursts_reached", 32'(exp_burst >= 24), 1);
    check("burst_final", 32'(burst_cnt), 32'(exp_burst));
    check("wrap_seen", 32'(saw_wrap), 1);
    check("no_ovf", 32'(ovf_err), 0);

    // Write into full with almost_full stuck low.
    do_reset("rst_pre_ovf");
    wait_write("ovf_start");
    cycle();
    cycle();
    af_stuck0  = 1;
    force_full = 1;
    full       = 1'b1;
    held       = fifo_wr_data;
    cycle();
    check("ovf_set", 32'(ovf_err), 1);
    check("ovf_data_held", 32'(fifo_wr_data), 32'(held));
    for (int i = 0; i < 3; i++) cycle();
    force_full = 0;
    full       = (q_cnt >= DEPTH);
    for (int i = 0; i < 5; i++) cycle();
    check("ovf_sticky", 32'(ovf_err), 1);
    af_stuck0 = 0;
    do_reset("rst_after_ovf");

    // Reset in DELAY, then in WRITE.
    for (int i = 0; i < 50 && busy !== 1'b1; i++) cycle();
    check("reach_delay", 32'({busy, fifo_wr_en}), 32'(2'b10));
    do_reset("rst_in_delay");
    wait_write("reach_write");
    for (int i = 0; i < 3; i++) cycle();
    do_reset("rst_in_write");

    // Empty glitch that never spans a clock edge must not start a burst.
    model_on = 0;
    do_reset("rst_glitch");
    empty = 1'b0; almost_full = 1'b0; full = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    #1 empty = 1'b1;
    #2 empty = 1'b0;
    busy_seen = 0;
    x_seen    = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (busy !== 1'b0) busy_seen++;
      if ($isunknown({fifo_wr_en, fifo_wr_data, burst_cnt, busy, ovf_err})) x_seen++;
    end
    check("glitch_no_delay", 32'(busy_seen), 0);
    check("glitch_no_x", 32'(x_seen), 0);
    empty = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("held_empty_starts", 32'(busy), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
